regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//   Parametrised integer register file with a per-register busy scoreboard.
//   Next-generation replacement for the RV32I datapath register file. Adds:
//   - write enable
//   - hardwired zero register
//   - optional write-to-read bypass
//   - asynchronous clear
//   - issue/writeback busy tracking, so the control unit can detect RAW hazards
// PARAMETERS
//   XLEN     32  data width of each register
//   NREGS    32  number of registers; power of two, >= 2
//   BYPASS   1   1: a same-cycle write is forwarded to read ports; 0: reads return stored value
//   AW       $clog2(NREGS)  localparam; register index width
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   we         in   1     writeback enable
//   rd         in   AW    writeback register index
//   rd_in      in   XLEN  writeback data
//   rs1        in   AW    read port 1 index
//   rs2        in   AW    read port 2 index
//   rs1_out    out  XLEN  read port 1 data (combinational)
//   rs2_out    out  XLEN  read port 2 data (combinational)
//   iss_en     in   1     issue: mark iss_rd busy (producer in flight)
//   iss_rd     in   AW    issue destination index
//   flush      in   1     synchronous clear of all busy bits
//   rs1_busy   out  1     rs1 has a pending producer (after bypass)
//   rs2_busy   out  1     rs2 has a pending producer (after bypass)
//   hazard     out  1     rs1_busy | rs2_busy
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous, no clock needed):
//   - all registers := 0; all busy bits := 0
//   - hence rs*_out=0, rs*_busy=0, hazard=0 while rst_n=0
//   - reset mid-operation discards any pending write/issue of that cycle
//   Writes:
//   - on posedge clk with we=1 and rd!=0: reg[rd] := rd_in
//   - we=0 or rd==0: no register changes
//   Register 0:
//   - always reads 0
//   - never busy; iss_en with iss_rd==0 is ignored
//   Reads are combinational; no latency.
//   - rsN==0 -> 0
//   - else if BYPASS && we && rd==rsN -> rd_in
//   - else reg[rsN]
//   Scoreboard (posedge clk), priority highest first:
//   1. flush=1: all busy bits := 0; iss_en/we effects on busy ignored that cycle.
//      The register write still occurs.
//   2. iss_en=1, iss_rd!=0: busy[iss_rd] := 1. Set wins over a same-cycle clear of
//      the same index (new producer supersedes old).
//   3. we=1, rd!=0: busy[rd] := 0, unless set by item 2 in the same cycle.
//   - A write to a non-busy register is legal; busy stays 0.
//   rsN_busy (combinational):
//   - busy[rsN] && rsN!=0
//   - masked to 0 when BYPASS && we && rd==rsN (value arrives this cycle)
//   - BYPASS=0: unmasked; a reader sees busy=0 the cycle after writeback
//   No wrap-around: AW indexes exactly NREGS entries. All 2^AW indices are valid.
// TESTING
//   1. Hold rst_n=0 after writes; release. Read x1..x31 -> all 0, hazard=0.
//   2. Write rd=5 rd_in=32'hDEADBEEF. Next cycle rs1=5 rs2=0 -> rs1_out=DEADBEEF,
//      rs2_out=0. Write rd=0 rd_in=FFFFFFFF -> rs1=0 still reads 0.
//   3. BYPASS=1: same cycle we=1 rd=7 rd_in=32'h1234, rs2=7 -> rs2_out=1234.
//      BYPASS=0: rs2_out=old value (0), then 1234 after the edge.
//   4. iss_en rd=3, then rs1=3 -> rs1_busy=1, hazard=1. Writeback rd=3: with BYPASS=1,
//      busy masked that cycle; next cycle busy=0.
//      iss_en rd=3 and we rd=3 in the same cycle -> busy[3]=1 afterwards.
//   5. Issue rd=4,9,31; assert flush -> next cycle all busy=0.
//      Then iss_en rd=0 -> rs1=0 busy=0.
//   6. Randomised: 1000 cycles of we/rd/rd_in/iss_en/flush checked against a reference
//      model. Includes rst_n pulsed low between clock edges -> immediate zeroing.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with hardwired x0, optional write-to-read bypass and a
// per-register busy scoreboard for RAW hazard detection.
module regfile_sb_rport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                        rst_n,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy,
  input  logic                        we,
  input  logic [AW-1:0]               rd,
  input  logic [XLEN-1:0]             rd_in,
  input  logic [AW-1:0]               rs,
  output logic [XLEN-1:0]             data,
  output logic                        rs_busy
);
  logic fwd;

  // Forwarding is suppressed in reset so every read port is 0 while rst_n is low.
  assign fwd = (BYPASS != 0) && rst_n && we && (rd == rs);

  always_comb begin
    data    = '0;
    rs_busy = 1'b0;
    if (rs != '0) begin
      data    = fwd ? rd_in : regs[rs];
      rs_busy = busy[rs] && !fwd;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_in,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            hazard
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [1:0][AW-1:0]         rs_idx;
  logic [1:0][XLEN-1:0]       rs_data;
  logic [1:0]                 rs_bsy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (we && rd != '0) regs[rd] <= rd_in;
      if (flush) begin
        busy <= '0;
      end else begin
        if (we && rd != '0)         busy[rd]     <= 1'b0;
        // Issued after the clear so a new producer supersedes a same-cycle writeback.
        if (iss_en && iss_rd != '0) busy[iss_rd] <= 1'b1;
      end
    end
  end

  assign rs_idx = {rs2, rs1};

  for (genvar g = 0; g < 2; g++) begin : g_rport
    regfile_sb_rport #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rport (
      .rst_n   (rst_n),
      .regs    (regs),
      .busy    (busy),
      .we      (we),
      .rd      (rd),
      .rd_in   (rd_in),
      .rs      (rs_idx[g]),
      .data    (rs_data[g]),
      .rs_busy (rs_bsy[g])
    );
  end

  assign rs1_out  = rs_data[0];
  assign rs2_out  = rs_data[1];
  assign rs1_busy = rs_bsy[0];
  assign rs2_busy = rs_bsy[1];
  assign hazard   = |rs_bsy;
endmodule
